// File: rtl/square_and_multiply_pkg.sv
// Shared definitions for the square-and-multiply modular exponentiator.
//   state_t                : exponentiator FSM states
//   DEFAULT_BUS_WIDTH      : default operand/result width
//   DEFAULT_COUNTER_WIDTH  : default exponent bit-index counter width
//   DEFAULT_MULT_WIDTH     : default modular multiplier accumulator width
//   mult_width()           : accumulator width for a given operand width
package sq_mul_pkg;

  localparam int unsigned DEFAULT_BUS_WIDTH     = 2048;
  localparam int unsigned DEFAULT_COUNTER_WIDTH = 11;

  // Two guard bits: 2P + y < 3n < 2^(BUS_WIDTH+2) before reduction.
  function automatic int unsigned mult_width(input int unsigned bus_width);
    return bus_width + 2;
  endfunction

  localparam int unsigned DEFAULT_MULT_WIDTH = DEFAULT_BUS_WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    SQUARE,
    MULT,
    DONE
  } state_t;

endpackage

// File: rtl/square_and_multiply_mod_mult.sv
// Interleaved shift-add modular multiplier: product = x*y mod n (needs y < n).
// One run takes BUS_WIDTH+1 edges after start is sampled; done pulses for
// one cycle together with the registered product.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   start      : load operands and begin (sampled each edge)
//   x, y, n    : multiplicand, multiplier, modulus
//   done       : one-cycle completion pulse
//   product    : x*y mod n, held until the next completion
module mod_mult
  import sq_mul_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = DEFAULT_BUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] x,
  input  logic [BUS_WIDTH-1:0] y,
  input  logic [BUS_WIDTH-1:0] n,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] product
);

  localparam int unsigned MW = mult_width(BUS_WIDTH);
  localparam int unsigned CW = $clog2(BUS_WIDTH + 1);

  logic                 busy_q, busy_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] x_q, x_d;
  logic [MW-1:0]        y_q, y_d;
  logic [MW-1:0]        n_q, n_d;
  logic [MW-1:0]        p_q, p_d;
  logic                 done_q, done_d;
  logic [BUS_WIDTH-1:0] prod_q, prod_d;

  logic [MW-1:0] p_dbl;
  logic [MW-1:0] p_sum;
  logic [MW-1:0] p_sub1;
  logic [MW-1:0] p_step;

  // One MSB-first step: P = 2P + x[i]*y, then at most two subtractions of n.
  always_comb begin
    p_dbl  = {p_q[MW-2:0], 1'b0};
    p_sum  = p_dbl + (x_q[BUS_WIDTH-1] ? y_q : '0);
    p_sub1 = (p_sum >= n_q) ? (p_sum - n_q) : p_sum;
    p_step = (p_sub1 >= n_q) ? (p_sub1 - n_q) : p_sub1;
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    x_d    = x_q;
    y_d    = y_q;
    n_d    = n_q;
    p_d    = p_q;
    done_d = 1'b0;
    prod_d = prod_q;
    if (start) begin
      x_d    = x;
      y_d    = {2'b00, y};
      n_d    = {2'b00, n};
      p_d    = '0;
      cnt_d  = CW'(BUS_WIDTH - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      p_d = p_step;
      x_d = x_q << 1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        prod_d = p_step[BUS_WIDTH-1:0];
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      n_q    <= '0;
      p_q    <= '0;
      done_q <= 1'b0;
      prod_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      n_q    <= n_d;
      p_q    <= p_d;
      done_q <= done_d;
      prod_q <= prod_d;
    end
  end

  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: rtl/square_and_multiply.sv
// Sequential modular exponentiator: result = m^e mod n (left-to-right binary).
// Every exponent bit is scanned; each square/multiply is one mod_mult run.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   m, e, n    : base, exponent, modulus (latched on the start edge)
//   ready      : start request, honoured in IDLE or DONE only
//   result     : registered m^e mod n
//   valid      : high while result holds a completed answer
module square_and_multiply
  import sq_mul_pkg::*;
#(
  parameter int unsigned BUS_WIDTH     = DEFAULT_BUS_WIDTH,
  parameter int unsigned COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] m,
  input  logic [BUS_WIDTH-1:0] e,
  input  logic [BUS_WIDTH-1:0] n,
  input  logic                 ready,
  output logic [BUS_WIDTH-1:0] result,
  output logic                 valid
);

  state_t                   state_q, state_d;
  logic [BUS_WIDTH-1:0]     m_q, m_d;
  logic [BUS_WIDTH-1:0]     e_q, e_d;
  logic [BUS_WIDTH-1:0]     n_q, n_d;
  logic [BUS_WIDTH-1:0]     b_q, b_d;
  logic [BUS_WIDTH-1:0]     acc_q, acc_d;
  logic [COUNTER_WIDTH-1:0] idx_q, idx_d;
  logic                     start_q, start_d;
  logic [BUS_WIDTH-1:0]     result_q, result_d;
  logic                     valid_q, valid_d;

  logic [BUS_WIDTH-1:0] mm_x;
  logic [BUS_WIDTH-1:0] mm_y;
  logic                 mm_done;
  logic [BUS_WIDTH-1:0] mm_product;

  // Operand mux reads only registered state, so it is stable on the edge
  // where mod_mult samples start_q.
  always_comb begin
    mm_x = acc_q;
    mm_y = acc_q;
    case (state_q)
      REDUCE:  begin mm_x = m_q;   mm_y = BUS_WIDTH'(1); end
      MULT:    begin mm_x = acc_q; mm_y = b_q;           end
      default: begin mm_x = acc_q; mm_y = acc_q;         end
    endcase
  end

  mod_mult #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_mod_mult (
    .clk    (clk),
    .reset  (reset),
    .start  (start_q),
    .x      (mm_x),
    .y      (mm_y),
    .n      (n_q),
    .done   (mm_done),
    .product(mm_product)
  );

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    n_d      = n_q;
    b_d      = b_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    start_d  = 1'b0;
    result_d = result_q;
    valid_d  = valid_q;
    case (state_q)
      IDLE, DONE: begin
        if (ready) begin
          m_d     = m;
          e_d     = e;
          n_d     = n;
          valid_d = 1'b0;
          start_d = 1'b1;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (mm_done) begin
          b_d     = mm_product;
          // 1 mod n; the n=0 and n=1 cases both collapse to 0.
          acc_d   = (n_q > BUS_WIDTH'(1)) ? BUS_WIDTH'(1) : '0;
          idx_d   = COUNTER_WIDTH'(BUS_WIDTH - 1);
          start_d = 1'b1;
          state_d = SQUARE;
        end
      end
      SQUARE, MULT: begin
        if (mm_done) begin
          acc_d = mm_product;
          if (state_q == SQUARE && e_q[idx_q]) begin
            start_d = 1'b1;
            state_d = MULT;
          end else if (idx_q == '0) begin
            result_d = mm_product;
            valid_d  = 1'b1;
            state_d  = DONE;
          end else begin
            idx_d   = idx_q - COUNTER_WIDTH'(1);
            start_d = 1'b1;
            state_d = SQUARE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      m_q      <= '0;
      e_q      <= '0;
      n_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      start_q  <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      e_q      <= e_d;
      n_q      <= n_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result = result_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_square_and_multiply.sv
module tb_square_and_multiply;

  localparam int unsigned BW = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] m, e, n;
  logic          ready;
  logic [BW-1:0] result;
  logic          valid;

  int checks = 0;
  int errors = 0;

  square_and_multiply #(
    .BUS_WIDTH    (BW),
    .COUNTER_WIDTH(CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .m     (m),
    .e     (e),
    .n     (n),
    .ready (ready),
    .result(result),
    .valid (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] m;
    logic [BW-1:0] e;
    logic [BW-1:0] n;
    logic [BW-1:0] res;
  } vec_t;

  // Right-to-left exponentiation with plain integer arithmetic.
  function automatic longint unsigned ref_modexp(input longint unsigned bm,
                                                 input longint unsigned be,
                                                 input longint unsigned bn);
    longint unsigned r, b, x;
    if (bn == 0) return 0;
    r = 1 % bn;
    b = bm % bn;
    x = be;
    while (x != 0) begin
      if (x[0]) r = (r * b) % bn;
      b = (b * b) % bn;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int ref_latency(input logic [BW-1:0] ex);
    return (1 + BW + $countones(ex)) * (BW + 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic start_op(input logic [BW-1:0] am, input logic [BW-1:0] ae,
                          input logic [BW-1:0] an);
    m = am; e = ae; n = an; ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  // Cycles from the start edge until valid is seen; -1 on timeout.
  task automatic wait_valid(input int max_cycles, output int cycles);
    cycles = 0;
    while (!valid && cycles < max_cycles) begin
      tick();
      cycles++;
    end
    if (!valid) begin
      cycles = -1;
      check("valid_timeout", 0, 1);
    end
  endtask

  vec_t vecs[7];
  int   cyc;
  int   bad;

  initial begin
    vecs[0] = '{m: 16'd4,   e: 16'd13, n: 16'd497,  res: 16'd445};
    vecs[1] = '{m: 16'd2,   e: 16'd10, n: 16'd1000, res: 16'd24};
    vecs[2] = '{m: 16'd10,  e: 16'd1,  n: 16'd7,    res: 16'd3};
    vecs[3] = '{m: 16'd5,   e: 16'd0,  n: 16'd7,    res: 16'd1};
    vecs[4] = '{m: 16'd9,   e: 16'd5,  n: 16'd1,    res: 16'd0};
    vecs[5] = '{m: 16'd0,   e: 16'd3,  n: 16'd11,   res: 16'd0};
    vecs[6] = '{m: 16'd123, e: 16'd45, n: 16'd0,    res: 16'd0};

    reset = 1'b1; ready = 1'b0; m = '0; e = '0; n = '0;
    tick(); tick();
    reset = 1'b0;
    check("reset_valid", valid, 0);
    check("reset_result", result, 0);

    // Back-to-back table runs
    foreach (vecs[i]) begin
      start_op(vecs[i].m, vecs[i].e, vecs[i].n);
      check($sformatf("vec%0d_valid_drop", i), valid, 0);
      wait_valid(ref_latency(vecs[i].e) + 100, cyc);
      check($sformatf("vec%0d_result", i), result, vecs[i].res);
      check($sformatf("vec%0d_latency", i), cyc, ref_latency(vecs[i].e));
      if (i == 0) begin
        bad = 0;
        repeat (100) begin
          tick();
          if (!valid || result !== 16'd445) bad++;
        end
        check("hold_100", bad, 0);
      end
    end

    // Re-pulse ready while busy: ignored
    start_op(16'd4, 16'd13, 16'd497);
    repeat (20) tick();
    start_op(16'd7, 16'd3, 16'd11);
    wait_valid(ref_latency(16'd13) + 100, cyc);
    check("repulse_result", result, 445);
    check("repulse_latency", cyc + 21, ref_latency(16'd13));

    // Reset mid-operation
    start_op(16'd4, 16'd13, 16'd497);
    repeat (30) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_valid", valid, 0);
    check("midreset_result", result, 0);
    start_op(16'd2, 16'd10, 16'd1000);
    wait_valid(ref_latency(16'd10) + 100, cyc);
    check("after_reset_result", result, 24);
    check("after_reset_latency", cyc, ref_latency(16'd10));

    // Reset and ready in the same cycle: reset wins
    m = 16'd4; e = 16'd13; n = 16'd497; ready = 1'b1; reset = 1'b1;
    tick();
    ready = 1'b0; reset = 1'b0;
    check("rst_ready_valid", valid, 0);
    check("rst_ready_result", result, 0);
    repeat (ref_latency(16'd13) + 20) tick();
    check("rst_ready_no_start", valid, 0);

    // Randomized regression against the reference model
    for (int t = 0; t < 60; t++) begin
      logic [BW-1:0] rm, re, rn;
      rm = BW'($urandom);
      re = BW'($urandom);
      rn = BW'($urandom_range(2, 65535));
      start_op(rm, re, rn);
      wait_valid(ref_latency(re) + 100, cyc);
      check($sformatf("rand%0d_result m=%0d e=%0d n=%0d", t, rm, re, rn),
            result, ref_modexp(rm, re, rn));
      check($sformatf("rand%0d_latency", t), cyc, ref_latency(re));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
